// File: rtl/buyruk_bellegi_if.sv
// Fetch and boot-loader bus of the instruction memory.
// master drives fetch address and loader bytes; slave is the memory.
interface buyruk_bellegi_if;
    logic [31:0] ps;
    logic [31:0] buyruk;
    logic        islemci_rst;
    logic        yukle_basla;
    logic        yukle_gecerli;
    logic [7:0]  yukle_bayt;
    logic        yukle_son;
    logic        yukle_hazir;
    logic        hata;

    modport master (
        output ps,
        output yukle_basla,
        output yukle_gecerli,
        output yukle_bayt,
        output yukle_son,
        input  buyruk,
        input  islemci_rst,
        input  yukle_hazir,
        input  hata
    );

    modport slave (
        input  ps,
        input  yukle_basla,
        input  yukle_gecerli,
        input  yukle_bayt,
        input  yukle_son,
        output buyruk,
        output islemci_rst,
        output yukle_hazir,
        output hata
    );
endinterface

// File: rtl/buyruk_bellegi.sv
// Instruction memory with byte-stream boot loader.
// Holds the core in reset while loading, then serves registered fetches.
module buyruk_bellegi #(
    parameter int          DERINLIK = 256,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    buyruk_bellegi_if.slave  bus
);
    localparam int AW = $clog2(DERINLIK);

    typedef enum logic {LOAD, RUN} durum_t;

    durum_t      durum_q, durum_d;
    logic [AW:0] ptr_q, ptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [1:0]  bidx_q, bidx_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] buyruk_q, buyruk_d;
    logic        irst_q, irst_d;
    logic        hata_q, hata_d;
    logic        ilk_q, ilk_d;

    logic [31:0] mem_q [DERINLIK];
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [31:0]   kelime;
    logic          tamam;
    logic [29:0]   idx;
    logic          isabet;

    // Next-state, byte assembly and fetch lookup
    always_comb begin
        durum_d  = durum_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        bidx_d   = bidx_q;
        asm_d    = asm_q;
        buyruk_d = buyruk_q;
        irst_d   = irst_q;
        hata_d   = hata_q;
        ilk_d    = ilk_q;
        mem_we   = 1'b0;
        mem_adr  = ptr_q[AW-1:0];
        tamam    = 1'b0;
        kelime   = asm_q | ({24'b0, bus.yukle_bayt} << {bidx_q, 3'b000});
        idx      = bus.ps[31:2];
        isabet   = idx < {{(30-AW-1){1'b0}}, cnt_q};
        unique case (durum_q)
            LOAD: begin
                buyruk_d = NOP;
                if (bus.yukle_gecerli) begin
                    tamam  = (bidx_q == 2'd3) || bus.yukle_son;
                    bidx_d = bus.yukle_son ? 2'd0 : bidx_q + 2'd1;
                    asm_d  = tamam ? 32'b0 : kelime;
                    if (tamam) begin
                        if (!ptr_q[AW]) begin
                            mem_we = 1'b1;
                            ptr_d  = ptr_q + 1'b1;
                            cnt_d  = cnt_q + 1'b1;
                        end else begin
                            hata_d = 1'b1;
                        end
                    end
                    if (bus.yukle_son) begin
                        durum_d = RUN;
                        ilk_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.yukle_basla) begin
                    durum_d  = LOAD;
                    ptr_d    = '0;
                    cnt_d    = '0;
                    bidx_d   = '0;
                    asm_d    = '0;
                    hata_d   = 1'b0;
                    irst_d   = 1'b1;
                    ilk_d    = 1'b0;
                    buyruk_d = NOP;
                end else if (ilk_q) begin
                    irst_d   = 1'b0;
                    ilk_d    = 1'b0;
                    buyruk_d = mem_q[0];
                end else if (bus.ps[1:0] != 2'b00) begin
                    buyruk_d = NOP;
                    hata_d   = 1'b1;
                end else if (isabet) begin
                    buyruk_d = mem_q[idx[AW-1:0]];
                end else begin
                    buyruk_d = NOP;
                end
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum_q  <= LOAD;
            ptr_q    <= '0;
            cnt_q    <= '0;
            bidx_q   <= '0;
            asm_q    <= '0;
            buyruk_q <= NOP;
            irst_q   <= 1'b1;
            hata_q   <= 1'b0;
            ilk_q    <= 1'b0;
        end else begin
            durum_q  <= durum_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            bidx_q   <= bidx_d;
            asm_q    <= asm_d;
            buyruk_q <= buyruk_d;
            irst_q   <= irst_d;
            hata_q   <= hata_d;
            ilk_q    <= ilk_d;
        end
    end

    // Memory array write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_adr] <= kelime;
        end
    end

    assign bus.buyruk      = buyruk_q;
    assign bus.islemci_rst = irst_q;
    assign bus.yukle_hazir = (durum_q == LOAD);
    assign bus.hata        = hata_q;
endmodule

// File: tb/tb_buyruk_bellegi.sv
// Scoreboard bench for the instruction memory and boot loader.
// Uses a 4-word memory so overflow is reachable.
module tb_buyruk_bellegi;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   toplam;
    int   gecen;
    logic [31:0] beklenen_q[$];

    buyruk_bellegi_if bus();

    buyruk_bellegi #(.DERINLIK(4), .NOP(NOP)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic kontrol(input string etiket,
                           input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        toplam++;
        if (gozlenen === beklenen) begin
            gecen++;
        end else begin
            $display("FAIL %s: got %h expected %h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bayt_gonder(input logic [7:0] b, input logic son);
        bus.yukle_gecerli = 1'b1;
        bus.yukle_bayt    = b;
        bus.yukle_son     = son;
        tick();
        bus.yukle_gecerli = 1'b0;
        bus.yukle_son     = 1'b0;
    endtask

    task automatic getir(input string etiket,
                         input logic [31:0] adr,
                         input logic [31:0] bek);
        bus.ps = adr;
        beklenen_q.push_back(bek);
        tick();
        kontrol(etiket, bus.buyruk, beklenen_q.pop_front());
    endtask

    task automatic basla_darbe();
        bus.yukle_basla = 1'b1;
        tick();
        bus.yukle_basla = 1'b0;
    endtask

    // Last loader byte at E0, handoff checks at E0 and E1
    task automatic devir(input string etiket, input logic [7:0] b,
                         input logic [31:0] ilk_kelime);
        bus.ps = 32'h2;
        bayt_gonder(b, 1'b1);
        kontrol({etiket, "_e0_rst"}, {31'b0, bus.islemci_rst}, 32'd1);
        kontrol({etiket, "_e0_hazir"}, {31'b0, bus.yukle_hazir}, 32'd0);
        tick();
        kontrol({etiket, "_e1_rst"}, {31'b0, bus.islemci_rst}, 32'd0);
        kontrol({etiket, "_e1_buyruk"}, bus.buyruk, ilk_kelime);
        kontrol({etiket, "_e1_hata"}, {31'b0, bus.hata}, 32'd0);
    endtask

    task automatic sifir_kontrol(input string etiket);
        kontrol({etiket, "_buyruk"}, bus.buyruk, NOP);
        kontrol({etiket, "_rst"}, {31'b0, bus.islemci_rst}, 32'd1);
        kontrol({etiket, "_hazir"}, {31'b0, bus.yukle_hazir}, 32'd1);
        kontrol({etiket, "_hata"}, {31'b0, bus.hata}, 32'd0);
    endtask

    logic [7:0] prog1 [8];
    logic [7:0] b;

    initial begin
        toplam = 0;
        gecen  = 0;
        prog1  = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        rst = 1'b1;
        bus.ps            = '0;
        bus.yukle_basla   = 1'b0;
        bus.yukle_gecerli = 1'b0;
        bus.yukle_bayt    = '0;
        bus.yukle_son     = 1'b0;
        #12;
        sifir_kontrol("reset");
        rst = 1'b0;

        // Two-word program
        for (int i = 0; i < 7; i++) begin
            bayt_gonder(prog1[i], 1'b0);
            kontrol("p1_rst_hold", {31'b0, bus.islemci_rst}, 32'd1);
        end
        devir("p1", prog1[7], 32'h00500513);
        getir("p1_ps4", 32'h4, 32'h00A00593);
        getir("p1_ps0", 32'h0, 32'h00500513);
        getir("p1_ps8", 32'h8, NOP);
        kontrol("p1_hata_clean", {31'b0, bus.hata}, 32'd0);
        getir("p1_ps2", 32'h2, NOP);
        kontrol("p1_hata_set", {31'b0, bus.hata}, 32'd1);
        getir("p1_ps0_again", 32'h0, 32'h00500513);
        kontrol("p1_hata_sticky", {31'b0, bus.hata}, 32'd1);

        // Reload with a single full word
        basla_darbe();
        kontrol("r_rst", {31'b0, bus.islemci_rst}, 32'd1);
        kontrol("r_buyruk", bus.buyruk, NOP);
        kontrol("r_hata_clr", {31'b0, bus.hata}, 32'd0);
        kontrol("r_hazir", {31'b0, bus.yukle_hazir}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            bayt_gonder(8'hFF, 1'b0);
            kontrol("r_rst_hold", {31'b0, bus.islemci_rst}, 32'd1);
        end
        devir("r", 8'hFF, 32'hFFFFFFFF);
        getir("r_ps4", 32'h4, NOP);
        getir("r_ps0", 32'h0, 32'hFFFFFFFF);

        // Partial last word is zero-padded
        basla_darbe();
        bayt_gonder(8'h01, 1'b0);
        bayt_gonder(8'h02, 1'b0);
        bayt_gonder(8'h03, 1'b0);
        bayt_gonder(8'h04, 1'b0);
        devir("pw", 8'hAA, 32'h04030201);
        getir("pw_ps4", 32'h4, 32'h000000AA);
        getir("pw_ps8", 32'h8, NOP);

        // Overflow: fifth word dropped
        basla_darbe();
        for (int i = 0; i < 19; i++) begin
            b = 8'(i + 8'h40);
            bayt_gonder(b, 1'b0);
            if (i == 15) begin
                kontrol("of_no_err_yet", {31'b0, bus.hata}, 32'd0);
            end
        end
        bus.yukle_gecerli = 1'b1;
        bus.yukle_bayt    = 8'h53;
        bus.yukle_son     = 1'b1;
        tick();
        bus.yukle_gecerli = 1'b0;
        bus.yukle_son     = 1'b0;
        kontrol("of_hata", {31'b0, bus.hata}, 32'd1);
        tick();
        kontrol("of_e1_buyruk", bus.buyruk, 32'h43424140);
        getir("of_ps12", 32'hC, 32'h4F4E4D4C);
        getir("of_ps16", 32'h10, NOP);
        kontrol("of_hata_sticky", {31'b0, bus.hata}, 32'd1);

        // Async reset mid-word, then a fresh word
        basla_darbe();
        bayt_gonder(8'h11, 1'b0);
        bayt_gonder(8'h22, 1'b0);
        #2 rst = 1'b1;
        #1;
        sifir_kontrol("arst");
        #1 rst = 1'b0;
        bayt_gonder(8'hA1, 1'b0);
        bayt_gonder(8'hB2, 1'b0);
        bayt_gonder(8'hC3, 1'b0);
        devir("arst", 8'hD4, 32'hD4C3B2A1);
        getir("arst_ps4", 32'h4, NOP);

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end
endmodule

// File: doc/buyruk_bellegi.md
# buyruk_bellegi

Instruction memory and boot loader that serves the other end of the core's fetch interface. It accepts a program as a byte stream over a valid/ready handshake, assembles the bytes little-endian into 32-bit words and holds the core in reset while loading. In RUN it returns a registered instruction word for the core's `ps` every cycle, in the same cycle-pairing the core expects.

## Interface

Parameters:
- `DERINLIK`, 256: number of 32-bit instruction words. Must be a power of two, at least 4.
- `NOP`, 32'h0000_0013: word returned for fetches that are unloaded, out of range or made during load (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `ps`  in  32  fetch byte address from the core.
- `buyruk`  out  32  registered instruction word to the core.
- `islemci_rst`  out  1  registered reset to the core; high while loading.
- `yukle_basla`  in  1  in RUN, a one-cycle pulse restarts loading.
- `yukle_gecerli`  in  1  loader byte valid.
- `yukle_bayt`  in  8  loader byte.
- `yukle_son`  in  1  qualifies the current byte as the last byte of the program.
- `yukle_hazir`  out  1  ready for a loader byte.
- `hata`  out  1  sticky error flag, cleared only by `rst` or a reload.

## Operation

- Reset values: state=LOAD, `buyruk`=NOP, `islemci_rst`=1, `yukle_hazir`=1, `hata`=0, word pointer=0, byte index=0, loaded count=0. Memory array contents are not cleared.
- States:
  - LOAD: `yukle_hazir`=1. A byte transfers when `yukle_gecerli`=1 and `yukle_hazir`=1.
    - Byte index k (0..3) fills bits [8k+7:8k] of the assembly register.
    - On k=3, the word is written to mem[pointer]; then pointer++ and loaded count++.
  - End of load: when the transferring byte has `yukle_son`=1:
    - Any partial word is written with its unfilled upper bytes zeroed, and the loaded count is incremented.
    - Next state is RUN.
  - RUN: `yukle_hazir`=0 and loader inputs are ignored. `yukle_basla`=1 returns to LOAD, clears pointer, byte index, loaded count and `hata`, and sets `islemci_rst`=1 on the next edge.
- Overflow: a completed word when pointer=DERINLIK is discarded, `hata`=1, and the pointer saturates. Loading continues until `yukle_son`.
- Fetch in RUN, with idx = ps[31:2]:
  - If idx < loaded count and ps[1:0]=0: `buyruk` <= mem[idx].
  - If idx >= loaded count: `buyruk` <= NOP.
  - If ps[1:0]!=0: `buyruk` <= NOP and `hata`=1.
- Fetch in LOAD: `buyruk` <= NOP.
- `yukle_son` with `yukle_gecerli`=0 has no effect.
- An empty program is not possible: the first byte carrying `yukle_son` yields a loaded count of 1.

## Timing

- Loader throughput: 1 byte per cycle, with no stalls in LOAD.
- A word is visible to fetch on the edge after its 4th byte, or after the `yukle_son` byte.
- LOAD->RUN handoff, with edge E0 being the `yukle_son` transfer:
  - E0: state<=RUN; `islemci_rst` stays 1.
  - E1: `islemci_rst`<=0 and `buyruk`<=mem[0], ignoring `ps`. At E1 the core still samples `islemci_rst`=1, so its ps_r=0.
  - E2 onward: `buyruk`<=lookup(`ps`). This gives 1-cycle read latency, matching the core's registered ps_r.
- `yukle_basla` pulse at edge E in RUN:
  - `islemci_rst`=1 and state=LOAD after E.
  - `buyruk`=NOP from E.
- `rst` asserted at any time, including mid-word or mid-run: all registers take their reset values immediately. A partial assembly word is discarded.

## Test plan

- Load 8 bytes 13,05,50,00,93,05,A0,00 (`yukle_son` on the last) -> mem[0]=0x00500513, mem[1]=0x00A00593; `islemci_rst` falls exactly 2 edges after the last byte; the first post-reset `buyruk`=0x00500513.
- After the load above, drive `ps`=4 -> `buyruk`=0x00A00593 one edge later; drive `ps`=8 -> NOP; drive `ps`=2 -> NOP and `hata`=1, which stays 1.
- Load 5 bytes 01,02,03,04,AA with `yukle_son` on AA -> mem[1]=0x000000AA, loaded count=2.
- With DERINLIK=4, stream 20 bytes -> the 5th word is dropped and `hata`=1; fetching `ps`=16 returns NOP.
- Pulse `yukle_basla` in RUN, then load 4 bytes FF,FF,FF,FF -> `islemci_rst` is 1 throughout, `hata` is cleared, and the new mem[0]=0xFFFFFFFF; `ps`=4 returns NOP.
- Assert `rst` asynchronously after 2 of 4 bytes, then reload 4 bytes -> the reset values appear immediately, and the word is assembled only from the new bytes.
